// File: rtl/mrf_pkg.sv
// mrf_pkg: clear-FSM state type and default sizes shared by multiport_reg_file.
package mrf_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  localparam int DEF_NUM_REGS   = 16;
  localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/mrf_clear_seq.sv
// mrf_clear_seq: clear FSM walking a counter over every register index, then one DONE cycle.
module mrf_clear_seq
  import mrf_pkg::*;
#(
  parameter  int NUM_REGS  = DEF_NUM_REGS,
  localparam int SEL_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                 i_clk,
  input  logic                 i_rstN,
  input  logic                 i_clrReq,
  output logic                 o_clrEn,
  output logic [SEL_WIDTH-1:0] o_clrIdx,
  output logic                 o_busy,
  output logic                 o_clrDone
);
  localparam logic [SEL_WIDTH:0] LAST = (SEL_WIDTH+1)'(NUM_REGS - 1);
  state_t               r_state;
  logic [SEL_WIDTH:0]   r_cnt;
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      o_busy    <= 1'b0;
      o_clrDone <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_clrReq) begin
          r_state <= CLEAR;
          r_cnt   <= '0;
          o_busy  <= 1'b1;
        end
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state   <= DONE;
            o_clrDone <= 1'b1;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          o_busy    <= 1'b0;
          o_clrDone <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_clrEn  = (r_state == CLEAR);
  assign o_clrIdx = r_cnt[SEL_WIDTH-1:0];
endmodule

// File: rtl/multiport_reg_file.sv
// multiport_reg_file: 1W/2R register file with write bypass and a sequenced whole-file clear.
// Define ZERO_REG_EN to hardwire reg[0] to zero.
module multiport_reg_file
  import mrf_pkg::*;
#(
  parameter  int NUM_REGS   = DEF_NUM_REGS,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int SEL_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rstN,
  input  logic                  i_wrEn,
  input  logic [SEL_WIDTH-1:0]  i_wrSel,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic [SEL_WIDTH-1:0]  i_rdSelA,
  input  logic [SEL_WIDTH-1:0]  i_rdSelB,
  output logic [DATA_WIDTH-1:0] o_rdDataA,
  output logic [DATA_WIDTH-1:0] o_rdDataB,
  input  logic                  i_clrReq,
  output logic                  o_busy,
  output logic                  o_clrDone,
  output logic                  o_wrDrop
);
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_clr_en;
  logic [SEL_WIDTH-1:0]  w_clr_idx;
  logic                  w_wr_acc;
  mrf_clear_seq #(.NUM_REGS(NUM_REGS)) u_clear_seq (
    .i_clk    (i_clk),
    .i_rstN   (i_rstN),
    .i_clrReq (i_clrReq),
    .o_clrEn  (w_clr_en),
    .o_clrIdx (w_clr_idx),
    .o_busy   (o_busy),
    .o_clrDone(o_clrDone)
  );
`ifdef ZERO_REG_EN
  // index 0 writes vanish without a drop pulse, so reg[0] and its bypass stay zero
  assign w_wr_acc = i_wrEn && !o_busy && (i_wrSel != '0);
`else
  assign w_wr_acc = i_wrEn && !o_busy;
`endif
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      o_rdDataA <= '0;
      o_rdDataB <= '0;
      o_wrDrop  <= 1'b0;
    end else begin
      if (w_clr_en) r_regs[w_clr_idx] <= '0;
      else if (w_wr_acc) r_regs[i_wrSel] <= i_wrData;
      o_rdDataA <= (w_wr_acc && i_wrSel == i_rdSelA) ? i_wrData : r_regs[i_rdSelA];
      o_rdDataB <= (w_wr_acc && i_wrSel == i_rdSelB) ? i_wrData : r_regs[i_rdSelB];
      o_wrDrop  <= i_wrEn && o_busy;
    end
  end
endmodule

// File: doc/multiport_reg_file.md
MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 Parameter NUM_REGS, default 16, number of registers (power of two, at least 2) SHALL be provided.
REQ-002 Parameter DATA_WIDTH, default 8, register width in bits SHALL be provided.
REQ-003 Localparam SEL_WIDTH = clog2(NUM_REGS) SHALL size all select ports.
REQ-004 Port i_clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port i_rstN, input, 1, reset; asynchronous and active-low.
REQ-006 Port i_wrEn, input, 1, write strobe.
REQ-007 Port i_wrSel, input, SEL_WIDTH, write register index.
REQ-008 Port i_wrData, input, DATA_WIDTH, write data.
REQ-009 Ports i_rdSelA and i_rdSelB, input, SEL_WIDTH each, read indices for ports A and B.
REQ-010 Ports o_rdDataA and o_rdDataB, output, DATA_WIDTH each, registered read data.
REQ-011 Port i_clrReq, input, 1, request to clear the whole file.
REQ-012 Port o_busy, output, 1, high while a clear is in progress.
REQ-013 Port o_clrDone, output, 1, one-cycle pulse when a clear completes.
REQ-014 Port o_wrDrop, output, 1, one-cycle pulse when a write strobe is discarded.

Function
REQ-015 When state is IDLE and i_wrEn=1, the block SHALL write i_wrData into reg[i_wrSel] at the edge.
REQ-016 Read ports SHALL have 1-cycle latency: o_rdDataX after edge N equals reg[i_rdSelX] as sampled at edge N.
REQ-017 Both read ports SHALL be independent; both may select the same index, including the write index.
REQ-018 Bypass: if an accepted write at edge N targets i_rdSelX, o_rdDataX after edge N SHALL equal i_wrData, not the old value.
REQ-019 The FSM SHALL have states IDLE, CLEAR and DONE; reset SHALL place it in IDLE.
REQ-020 IDLE->CLEAR transition: i_clrReq=1 at an edge; the clear counter SHALL load 0.
REQ-021 CLEAR behaviour: each cycle, reg[counter] is set to 0 and the counter increments; after index NUM_REGS-1 is written, the FSM SHALL move to DONE.
REQ-022 DONE->IDLE transition: unconditional after one cycle; o_clrDone=1 during DONE only.
REQ-023 o_busy SHALL equal 1 in CLEAR and DONE, and 0 in IDLE.
REQ-024 i_wrEn=1 in CLEAR or DONE SHALL be ignored and SHALL produce o_wrDrop=1 in the next cycle.
REQ-025 i_clrReq while in CLEAR or DONE SHALL be ignored; it SHALL not restart or extend the clear.
REQ-026 Simultaneous i_wrEn and i_clrReq in IDLE: the write SHALL be performed, then the clear begins and zeroes it; o_wrDrop stays 0.
REQ-027 Reads during a clear SHALL return current contents: already-cleared entries return 0, uncleared entries return their old values.
REQ-028 Bypass SHALL not apply to a clear write; the clear write to reg[counter] SHALL be visible from the next read.
REQ-029 The counter SHALL be SEL_WIDTH+1 bits wide so that it does not wrap before the terminal comparison.

Reset
REQ-030 On i_rstN=0, asynchronously: all registers, o_rdDataA, o_rdDataB, o_busy, o_clrDone, o_wrDrop and the counter SHALL go to 0, and the FSM to IDLE.
REQ-031 Reset asserted mid-clear SHALL abort the clear with no o_clrDone pulse.
REQ-032 The first accepted write SHALL be at the first rising edge after deassertion.

Configuration
REQ-033 With ZERO_REG_EN defined, reg[0] SHALL always read 0: writes to index 0 are discarded silently (no o_wrDrop), and bypass to index 0 returns 0.
REQ-034 Without ZERO_REG_EN, reg[0] SHALL behave as a normal register.

Structure
REQ-035 Package mrf_pkg SHALL hold the FSM state enum (IDLE, CLEAR, DONE) and the default constants for NUM_REGS and DATA_WIDTH.
REQ-036 Sub-module mrf_clear_seq SHALL contain the FSM and counter, exposing clear-enable, clear-index, o_busy and o_clrDone.
REQ-037 Storage, write decode and read/bypass muxing SHALL stay in the top module.

Verification
REQ-038 With NUM_REGS=16 and DATA_WIDTH=8: write 10->r0, then 20->r3; then rdSelA=0 and rdSelB=3 -> A=10 and B=20 one cycle later.
REQ-039 Write 0x5A->r7 with rdSelA=7 at the same edge -> A=0x5A on the next cycle (bypass).
REQ-040 Fill all 16 registers with 0xFF, pulse i_clrReq -> o_busy high for 17 cycles, o_clrDone pulses on the 17th, then all reads return 0.
REQ-041 During a clear, i_wrEn with 0x33->r2 -> o_wrDrop pulses and r2 reads 0 after the clear.
REQ-042 Drop i_rstN at clear index 5 -> o_busy=0 immediately, no o_clrDone pulse, all reads return 0.
REQ-043 With ZERO_REG_EN defined: write 0x77->r0 -> r0 reads 0 and o_wrDrop=0; without the macro, r0 reads 0x77.
